// File: rtl/drfa_pkg.sv
// Shared definitions for the PC/flags sequencer: widths, control-op encodings, FSM states.
// Pure declarations; no logic, no latency.
package drfa_pkg;

  localparam int PC_W        = 9;
  localparam int FLAG_W      = 4;
  localparam int STACK_DEPTH = 5;
  localparam int DEPTH_W     = 3;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_HALT = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // Encodings 5..7 are reserved and behave as NEXT.
  function automatic op_e decode_op(input logic [2:0] raw);
    return (raw > 3'd4) ? OP_NEXT : op_e'(raw);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> call/return stack bus: push/pop strobes with frame data out, stack top in.
// Strobes are single-cycle commands; the stack never back-pressures.
interface pc_sequencer_if #(
  parameter int PC_W   = drfa_pkg::PC_W,
  parameter int FLAG_W = drfa_pkg::FLAG_W
);

  logic              push_en;
  logic              pop_en;
  logic [PC_W-1:0]   push_pc;
  logic [FLAG_W-1:0] push_flags;
  logic [PC_W-1:0]   stk_out_pc;
  logic [FLAG_W-1:0] stk_out_flags;

  modport master (
    output push_en, pop_en, push_pc, push_flags,
    input  stk_out_pc, stk_out_flags
  );

  modport slave (
    input  push_en, pop_en, push_pc, push_flags,
    output stk_out_pc, stk_out_flags
  );

endinterface

// File: rtl/depth_counter.sv
// Saturating up/down occupancy counter with full/empty flags; count updates one edge after inc/dec.
// Increment at full and decrement at empty are absorbed (count holds).
module depth_counter #(
  parameter int MAX = 5,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= W'(MAX));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC/flags sequencer feeding a call/return stack; new pc/flags/depth one edge after the action.
// en low freezes all state and suppresses push/pop; the stack accepts every strobe.
module pc_sequencer
  import drfa_pkg::*;
#(
  parameter int                      PC_W        = drfa_pkg::PC_W,
  parameter int                      FLAG_W      = drfa_pkg::FLAG_W,
  parameter int                      STACK_DEPTH = drfa_pkg::STACK_DEPTH,
  parameter logic [drfa_pkg::PC_W-1:0] RESET_PC  = '0,
  parameter logic [drfa_pkg::PC_W-1:0] IRQ_VECTOR = 'h1F0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [PC_W-1:0]   target,
  input  logic              flags_wr,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              irq,
  pc_sequencer_if.master    stk,
  output logic [PC_W-1:0]   pc,
  output logic [FLAG_W-1:0] flags,
  output logic [2:0]        depth,
  output logic              in_irq,
  output logic              irq_ack,
  output logic              ovf,
  output logic              fault
);

  state_e          state;
  op_e             op_dec;
  logic [PC_W-1:0] pc_inc;
  logic            irq_take;
  logic            run_op;
  logic            do_push;
  logic            do_pop;
  logic            full;
  logic            empty;

  assign op_dec = decode_op(op);
  assign pc_inc = pc + PC_W'(1);

  // rst_n gates the strobes so they drop immediately on reset assertion, not at the next edge.
  assign irq_take = rst_n && en && irq && !in_irq
                    && (state == ST_RUN || state == ST_HALTED);
  assign run_op   = rst_n && en && !irq_take && (state == ST_RUN);
  assign do_push  = irq_take || (run_op && op_dec == OP_CALL);
  assign do_pop   = run_op && op_dec == OP_RET && !empty;

  assign stk.push_en    = do_push;
  assign stk.pop_en     = do_pop;
  assign stk.push_pc    = irq_take ? pc : pc_inc;
  assign stk.push_flags = flags;

  assign fault = (state == ST_FAULT);

  depth_counter #(
    .MAX (STACK_DEPTH),
    .W   (3)
  ) u_depth (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_push),
    .dec   (do_pop),
    .count (depth),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      flags   <= '0;
      in_irq  <= 1'b0;
      irq_ack <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      irq_ack <= irq_take;
      // A push at full still goes out (stack overwrites its top); record the loss.
      if (do_push && full) begin
        ovf <= 1'b1;
      end
      if (irq_take) begin
        pc     <= IRQ_VECTOR;
        flags  <= '0;
        in_irq <= 1'b1;
        state  <= ST_RUN;
      end else if (run_op) begin
        unique case (op_dec)
          OP_JMP: begin
            pc <= target;
            if (flags_wr) flags <= flags_in;
          end
          OP_CALL: pc <= target;
          OP_RET: begin
            if (empty) begin
              state <= ST_FAULT;
            end else begin
              pc     <= stk.stk_out_pc;
              flags  <= stk.stk_out_flags;
              in_irq <= 1'b0;
            end
          end
          OP_HALT: state <= ST_HALTED;
          default: begin
            pc <= pc_inc;
            if (flags_wr) flags <= flags_in;
          end
        endcase
      end
    end
  end

  always_comb begin
    assert (!(stk.push_en && stk.pop_en));
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural stack plus a frame-list reference model, directed then random.
module tb_pc_sequencer;

  localparam int VEC = 'h1F0;
  localparam int SD  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] op = '0;
  logic [8:0] target = '0;
  logic       flags_wr = 1'b0;
  logic [3:0] flags_in = '0;
  logic       irq = 1'b0;
  logic [8:0] pc;
  logic [3:0] flags;
  logic [2:0] depth;
  logic       in_irq, irq_ack, ovf, fault;

  pc_sequencer_if #(.PC_W(9), .FLAG_W(4)) stk ();

  pc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .op       (op),
    .target   (target),
    .flags_wr (flags_wr),
    .flags_in (flags_in),
    .irq      (irq),
    .stk      (stk),
    .pc       (pc),
    .flags    (flags),
    .depth    (depth),
    .in_irq   (in_irq),
    .irq_ack  (irq_ack),
    .ovf      (ovf),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stack frames are encoded pc*16 + flags.
  int env_q[$];
  int m_stk[$];
  int m_pc, m_flags, m_mode, m_in_irq, m_ovf, m_ack;  // m_mode: 0 run, 1 halted, 2 fault
  int ret_exp[5] = '{6, 4, 3, 2, 1};

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_flags = 0; m_mode = 0; m_in_irq = 0; m_ovf = 0; m_ack = 0;
    m_stk.delete();
    env_q.delete();
  endtask

  task automatic m_push(input int p, input int f);
    if (m_stk.size() == SD) begin
      m_ovf = 1;
      m_stk[SD-1] = p * 16 + f;
    end else begin
      m_stk.push_back(p * 16 + f);
    end
  endtask

  task automatic check_regs();
    chk("pc", int'(pc), m_pc);
    chk("flags", int'(flags), m_flags);
    chk("depth", int'(depth), m_stk.size());
    chk("in_irq", int'(in_irq), m_in_irq);
    chk("irq_ack", int'(irq_ack), m_ack);
    chk("ovf", int'(ovf), m_ovf);
    chk("fault", int'(fault), int'(m_mode == 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    en = 1'b1; irq = 1'b1; op = 3'd2;
    rst_n = 1'b0;
    #1;
    chk("rst_push_en", int'(stk.push_en), 0);
    chk("rst_pop_en", int'(stk.pop_en), 0);
    model_reset();
    check_regs();
    @(negedge clk);
    en = 1'b0; irq = 1'b0; op = 3'd0;
    rst_n = 1'b1;
  endtask

  task automatic step(input bit e, input int o, input int tgt, input bit fw, input int fi, input bit ir);
    int e_push, e_pop, e_ppc, e_pfl, frame, top;
    logic a_push, a_pop;
    logic [8:0] a_ppc;
    logic [3:0] a_pfl;
    @(negedge clk);
    en = e; op = o[2:0]; target = tgt[8:0]; flags_wr = fw; flags_in = fi[3:0]; irq = ir;
    if (env_q.size() > 0) begin
      top = env_q[$];
      stk.stk_out_pc    = 9'(top >> 4);
      stk.stk_out_flags = 4'(top);
    end else begin
      stk.stk_out_pc    = 9'($urandom);
      stk.stk_out_flags = 4'($urandom);
    end
    #1;
    e_push = 0; e_pop = 0; e_ppc = 0; e_pfl = m_flags;
    m_ack = 0;
    if (e && m_mode != 2) begin
      if (ir && !m_in_irq) begin
        e_push = 1; e_ppc = m_pc;
        m_push(m_pc, m_flags);
        m_pc = VEC; m_flags = 0; m_in_irq = 1; m_ack = 1; m_mode = 0;
      end else if (m_mode == 0) begin
        case (o)
          1: begin m_pc = tgt; if (fw) m_flags = fi; end
          2: begin
            e_push = 1; e_ppc = (m_pc + 1) % 512;
            m_push(e_ppc, m_flags);
            m_pc = tgt;
          end
          3: begin
            if (m_stk.size() == 0) begin
              m_mode = 2;
            end else begin
              e_pop = 1;
              frame = m_stk.pop_back();
              m_pc = frame >> 4; m_flags = frame % 16; m_in_irq = 0;
            end
          end
          4: m_mode = 1;
          default: begin m_pc = (m_pc + 1) % 512; if (fw) m_flags = fi; end
        endcase
      end
    end
    a_push = stk.push_en; a_pop = stk.pop_en; a_ppc = stk.push_pc; a_pfl = stk.push_flags;
    chk("push_en", int'(a_push), e_push);
    chk("pop_en", int'(a_pop), e_pop);
    if (e_push != 0) begin
      chk("push_pc", int'(a_ppc), e_ppc);
      chk("push_flags", int'(a_pfl), e_pfl);
    end
    @(posedge clk);
    #1;
    if (a_push) begin
      if (env_q.size() == SD) env_q[SD-1] = int'(a_ppc) * 16 + int'(a_pfl);
      else env_q.push_back(int'(a_ppc) * 16 + int'(a_pfl));
    end else if (a_pop && env_q.size() > 0) begin
      void'(env_q.pop_back());
    end
    check_regs();
  endtask

  initial begin
    int o;
    stk.stk_out_pc = '0;
    stk.stk_out_flags = '0;
    do_reset();

    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("tp_next3", int'(pc), 3);
    step(1, 1, 'h1FF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("tp_wrap", int'(pc), 0);

    step(1, 1, 'h10, 1, 'hC, 0);
    step(1, 2, 'h40, 1, 'h5, 0);
    chk("tp_call_pc", int'(pc), 'h40);
    chk("tp_call_depth", int'(depth), 1);
    step(1, 3, 0, 0, 0, 0);
    chk("tp_ret_pc", int'(pc), 'h11);
    chk("tp_ret_flags", int'(flags), 'hC);

    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2, i + 1, 0, 0, 0);
    chk("tp_nest_depth", int'(depth), 5);
    chk("tp_nest_ovf", int'(ovf), 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 3, 0, 0, 0, 0);
      chk("tp_nest_ret", int'(pc), ret_exp[i]);
    end

    step(1, 3, 0, 0, 0, 0);
    chk("tp_fault", int'(fault), 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 2, 'h33, 0, 0, 1);
    chk("tp_frozen", int'(pc), 1);
    do_reset();

    step(1, 1, 'h20, 1, 'h3, 0);
    step(1, 2, 'h55, 1, 'h9, 1);
    chk("tp_irq_pc", int'(pc), 'h1F0);
    chk("tp_irq_ack", int'(irq_ack), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("tp_irq_ignored", int'(depth), 1);
    step(1, 3, 0, 0, 0, 0);
    chk("tp_irq_ret_pc", int'(pc), 'h20);
    chk("tp_irq_ret_flags", int'(flags), 'h3);

    step(1, 1, 'h05, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(i[0], 0, 0, 0, 0, 0);
    chk("tp_halt_pc", int'(pc), 5);
    step(1, 0, 0, 0, 0, 1);
    chk("tp_halt_irq_pc", int'(pc), 'h1F0);
    step(1, 0, 0, 0, 0, 0);
    chk("tp_halt_running", int'(pc), 'h1F1);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      o = int'($urandom_range(0, 7));
      if (m_stk.size() == 0 && o == 3 && $urandom_range(0, 3) != 0) o = 2;
      step($urandom_range(0, 7) != 0, o, int'($urandom_range(0, 511)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) == 0);
      if (m_mode == 2 || $urandom_range(0, 199) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and flags sequencer that sits directly upstream of the call/return `stack`. It owns the 9-bit PC and the 4-bit flags register, and it decodes the per-cycle control op from the decoder (NEXT/JMP/CALL/RET/HALT). It drives the stack's `push_en`/`pop_en`/`in_pc`/`in_flags`, and restores PC and flags from the stack's `out_pc`/`out_flags` on return. It also tracks stack depth, which the stack itself does not report, and handles interrupt entry.

## Interface
- `PC_W`, 9, PC and address width
- `FLAG_W`, 4, flags width
- `STACK_DEPTH`, 5, entries in the downstream stack
- `RESET_PC`, 0, PC after reset
- `IRQ_VECTOR`, 9'h1F0, PC loaded on interrupt entry

Ports:
- `clk`  in  1  single clock, all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  advance strobe; when low, all state holds and no push/pop is issued
- `op`  in  3  0 NEXT, 1 JMP, 2 CALL, 3 RET, 4 HALT, 5–7 treated as NEXT
- `target`  in  PC_W  jump/call destination
- `flags_wr`  in  1  load `flags_in` into flags (NEXT/JMP only)
- `flags_in`  in  FLAG_W  new flags value
- `irq`  in  1  level interrupt request
- `stk_out_pc`  in  PC_W  stack top PC
- `stk_out_flags`  in  FLAG_W  stack top flags
- `pc`  out  PC_W  current PC, registered
- `flags`  out  FLAG_W  current flags, registered
- `push_en`, `pop_en`  out  1  to stack, combinational, mutually exclusive
- `push_pc`  out  PC_W  to stack `in_pc`
- `push_flags`  out  FLAG_W  to stack `in_flags`
- `depth`  out  3  live entries, 0..STACK_DEPTH
- `in_irq`  out  1  interrupt handler active (set on entry, cleared by RET)
- `irq_ack`  out  1  one-cycle pulse on interrupt entry
- `ovf`  out  1  sticky: CALL or interrupt entry issued at full depth
- `fault`  out  1  high in FAULT state

## Operation
- States: RUN, HALTED, FAULT. Reset → RUN; `pc=RESET_PC`, `flags=0`, `depth=0`, `in_irq=0`, `ovf=0`, `irq_ack=0`, `push_en=pop_en=0`.
- An action fires only in RUN with `en=1`. Priority: interrupt > op.
- Interrupt fires when `irq=1` and `in_irq=0`:
  - push `pc` (the op this cycle is not executed) and `flags`
  - `pc←IRQ_VECTOR`, `flags←0`, `in_irq←1`, `irq_ack=1` for one cycle
- NEXT: `pc←pc+1`, wrapping modulo 2^PC_W.
- JMP: `pc←target`.
- CALL: push `pc+1` and `flags`, then `pc←target`.
- RET:
  - At `depth>0`: `pop_en=1`, `pc←stk_out_pc`, `flags←stk_out_flags`, `depth−1`, `in_irq←0`.
  - At `depth=0`: no pop, PC and flags hold, → FAULT.
- HALT: → HALTED, PC holds. HALTED exits only to RUN via an interrupt, and that interrupt entry pushes the halted PC.
- `flags_wr` applies on NEXT/JMP only; it is ignored on CALL, RET and interrupt entry.
- Push at `depth=STACK_DEPTH`: push still issued (the stack overwrites its top), `depth` saturates, `ovf←1`.
- FAULT is terminal until reset: `fault=1`, no push/pop.

## Timing
- `push_en`/`pop_en`/`push_pc`/`push_flags` are combinational in the same cycle as the action. The stack, `pc`, `flags` and `depth` all update on the same edge.
- On RET, the restored PC/flags are the pre-edge `stk_out_*` (the top before the pop).
- Latency: 1 cycle from action to new `pc`. `irq_ack` is registered and is high in the cycle after the entry edge.
- Reset asserted mid-operation clears everything immediately. Push/pop drop to 0 asynchronously.

## Structure
- Shared package `drfa_pkg`: op encodings, `PC_W`, `FLAG_W`, state enum.
- One sub-module, `depth_counter`: saturating up/down counter with full/empty outputs.

## Test plan
- Reset then 3× NEXT → `pc=3`, no push/pop. At `pc=9'h1FF`, NEXT → `pc=0`.
- `flags=4'b1100`, CALL `target=0x40` at `pc=0x10` → `push_en=1`, `push_pc=0x11`, `push_flags=4'b1100`, `pc=0x40`, `depth=1`. RET with `stk_out_pc=0x11`/`stk_out_flags=4'b1100` → `pop_en=1`, `pc=0x11`, `flags=4'b1100`, `depth=0`.
- 6 nested CALLs against the real stack → `depth=5`, `ovf=1`. 5 RETs return targets 6,4,3,2,1 in order.
- RET at `depth=0` → `fault=1`, `pc` frozen, later ops ignored until `rst_n` low.
- `irq=1` concurrent with CALL at `pc=0x20`, `flags=4'b0011` → push `0x20`/`4'b0011`, `pc=0x1F0`, `flags=0`, `irq_ack` pulse, CALL not executed. A second `irq` is ignored until RET.
- HALT at `pc=0x05`, then `en` toggled 4 cycles → `pc=0x05`. `irq` → push `0x05`, `pc=0x1F0`, state RUN.
